// File: rtl/div_dispatch.sv
// Issue/retire controller for the RV32IM divider. It holds the divider operands for
// DIV_LATENCY cycles and resolves the divide-by-zero and overflow cases without the divider.
module div_dispatch #(
  parameter int length      = 32,
  parameter int DIV_LATENCY = 1,
  parameter int TAG_W       = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [length-1:0] req_a,
  input  logic [length-1:0] req_b,
  input  logic              req_rem,
  input  logic [TAG_W-1:0]  req_tag,
  input  logic              flush,
  output logic [length-1:0] oper_a,
  output logic [length-1:0] oper_b,
  output logic              operation,
  output logic              enable_div,
  input  logic [length-1:0] div_o,
  output logic              res_valid,
  input  logic              res_ready,
  output logic [length-1:0] res_data,
  output logic [TAG_W-1:0]  res_tag,
  output logic              busy,
  output logic [1:0]        dbg_state
);

  // Handshakes: a transfer happens on a rising edge where valid && ready are both high.
  // req_ready is combinational from state and flush; res_valid stays high until res_ready.

  localparam int CNT_W = (DIV_LATENCY < 2) ? 1 : $clog2(DIV_LATENCY + 1);
  localparam logic [CNT_W-1:0]  LAT_CNT = CNT_W'(DIV_LATENCY);
  localparam logic [length-1:0] MIN_INT = {1'b1, {(length-1){1'b0}}};

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t            r_state;
  state_t            w_next;
  logic [CNT_W-1:0]  r_cnt;
  logic              w_accept;
  logic              w_last;
  logic              w_special;
  logic [length-1:0] w_special_res;

  assign req_ready = (r_state == IDLE) && !flush;
  assign busy      = (r_state != IDLE);
  assign dbg_state = r_state;
  assign w_accept  = req_valid && req_ready;
  assign w_last    = (r_cnt == LAT_CNT);

  // RISC-V defines these results directly, so the divider is never started for them.
  always_comb begin
    w_special     = 1'b0;
    w_special_res = '0;
    if (req_b == '0) begin
      w_special     = 1'b1;
      w_special_res = req_rem ? req_a : '1;
    end else if ((req_a == MIN_INT) && (req_b == '1)) begin
      w_special     = 1'b1;
      w_special_res = req_rem ? '0 : MIN_INT;
    end
  end

  always_comb begin
    w_next = r_state;
    if (flush) begin
      w_next = IDLE;
    end else begin
      case (r_state)
        IDLE:        if (w_accept) w_next = w_special ? DONE : ISSUE;
        ISSUE, WAIT: w_next = w_last ? DONE : WAIT;
        DONE:        if (res_ready) w_next = IDLE;
        default:     w_next = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_next;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      oper_a     <= '0;
      oper_b     <= '0;
      operation  <= 1'b0;
      enable_div <= 1'b0;
      res_valid  <= 1'b0;
      res_data   <= '0;
      res_tag    <= '0;
      r_cnt      <= '0;
    end else if (flush) begin
      enable_div <= 1'b0;
      res_valid  <= 1'b0;
      r_cnt      <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            res_tag <= req_tag;
            if (w_special) begin
              res_data  <= w_special_res;
              res_valid <= 1'b1;
            end else begin
              oper_a     <= req_a;
              oper_b     <= req_b;
              operation  <= req_rem;
              enable_div <= 1'b1;
              r_cnt      <= CNT_W'(1);
            end
          end
        end
        ISSUE, WAIT: begin
          // r_cnt counts enable_div edges; the divider output is valid on the last one.
          if (w_last) begin
            res_data   <= div_o;
            res_valid  <= 1'b1;
            enable_div <= 1'b0;
            r_cnt      <= '0;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        DONE: begin
          if (res_ready) res_valid <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_div_dispatch.sv
// Bench for div_dispatch: two instances (DIV_LATENCY 1 and 4), each with a fixed-latency divider
// model, directed and random requests, and a scoreboard fed at accept time.
`timescale 1ns/1ps
module tb_div_dispatch;
  localparam int W  = 32;
  localparam int TW = 5;
  localparam logic [W-1:0] MIN_INT = 32'h8000_0000;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  function automatic void chk(input int inst, input string name,
                              input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL [lat_inst %0d] %s: got 0x%08h expected 0x%08h", inst, name, act, exp);
    end
  endfunction

  // RISC-V M-extension result for a signed DIV/REM.
  function automatic logic [W-1:0] ref_res(input logic [W-1:0] a, input logic [W-1:0] b,
                                           input logic rem);
    logic signed [W-1:0] sa;
    logic signed [W-1:0] sb;
    sa = a;
    sb = b;
    if (b == '0) return rem ? a : '1;
    if (a == MIN_INT && b == '1) return rem ? '0 : MIN_INT;
    return rem ? W'(sa % sb) : W'(sa / sb);
  endfunction

  function automatic bit is_special(input logic [W-1:0] a, input logic [W-1:0] b);
    return (b == '0) || (a == MIN_INT && b == '1);
  endfunction

  for (genvar g = 0; g < 2; g++) begin : g_inst
    localparam int LAT = (g == 0) ? 1 : 4;

    logic          rst_n = 1'b0;
    logic          req_valid = 1'b0;
    logic          req_ready;
    logic [W-1:0]  req_a = '0;
    logic [W-1:0]  req_b = '0;
    logic          req_rem = 1'b0;
    logic [TW-1:0] req_tag = '0;
    logic          flush = 1'b0;
    logic [W-1:0]  oper_a, oper_b, div_o, res_data;
    logic          operation, enable_div, res_valid, busy;
    logic          res_ready;
    logic [TW-1:0] res_tag;
    logic [1:0]    dbg_state;
    bit            bp_rand = 1'b0;
    logic          rdy_val = 1'b1;
    bit            done = 1'b0;

    div_dispatch #(.length(W), .DIV_LATENCY(LAT), .TAG_W(TW)) u_dut (
      .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
      .req_a(req_a), .req_b(req_b), .req_rem(req_rem), .req_tag(req_tag), .flush(flush),
      .oper_a(oper_a), .oper_b(oper_b), .operation(operation), .enable_div(enable_div),
      .div_o(div_o), .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
      .res_tag(res_tag), .busy(busy), .dbg_state(dbg_state)
    );

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) begin
      #2;
      res_ready = bp_rand ? ($urandom_range(0, 3) != 0) : rdy_val;
    end

    // Divider model: output is garbage except on the LAT-th consecutive enable cycle.
    int en_cnt = 0;
    always @(posedge clk) en_cnt <= enable_div ? en_cnt + 1 : 0;
    always_comb begin
      div_o = 32'hDEAD_BEEF;
      if (enable_div && en_cnt == LAT - 1 && oper_b != '0)
        div_o = operation ? W'($signed(oper_a) % $signed(oper_b))
                          : W'($signed(oper_a) / $signed(oper_b));
    end

    logic [W-1:0]  exp_q[$];
    logic [TW-1:0] exp_tag_q[$];
    int            exp_lat_q[$];
    int            exp_en_q[$];
    int            acc_cyc_q[$];

    int            en_seen = 0;
    bit            in_done = 1'b0;
    logic [W-1:0]  ha, hb, cur_d;
    logic          hop;
    logic [TW-1:0] cur_t;

    always @(negedge clk) begin
      if (!rst_n || flush) begin
        en_seen = 0;
        in_done = 1'b0;
      end else begin
        if (enable_div) begin
          if (en_seen == 0) begin
            ha = oper_a; hb = oper_b; hop = operation;
          end else begin
            chk(g, "oper_a_held", oper_a, ha);
            chk(g, "oper_b_held", oper_b, hb);
            chk(g, "operation_held", 32'(operation), 32'(hop));
          end
          en_seen++;
        end
        if (res_valid) begin
          if (!in_done) begin
            if (exp_q.size() == 0) begin
              chk(g, "unexpected_res_valid", 32'(res_valid), 32'd0);
            end else begin
              in_done = 1'b1;
              cur_d = exp_q.pop_front();
              cur_t = exp_tag_q.pop_front();
              chk(g, "edges_accept_to_valid", 32'(cyc - acc_cyc_q.pop_front()),
                  32'(exp_lat_q.pop_front()));
              chk(g, "enable_div_cycles", 32'(en_seen), 32'(exp_en_q.pop_front()));
            end
          end
          if (in_done) begin
            chk(g, "res_data", res_data, cur_d);
            chk(g, "res_tag", 32'(res_tag), 32'(cur_t));
            chk(g, "req_ready_in_done", 32'(req_ready), 32'd0);
            chk(g, "enable_div_in_done", 32'(enable_div), 32'd0);
            if (res_ready) begin
              in_done = 1'b0;
              en_seen = 0;
            end
          end
        end
      end
    end

    task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b, input logic rem,
                         input logic [TW-1:0] tag, input bit track);
      bit ok = 1'b0;
      req_a = a; req_b = b; req_rem = rem; req_tag = tag; req_valid = 1'b1;
      for (int i = 0; i < 200 && !ok; i++) begin
        @(negedge clk);
        if (req_ready) begin
          ok = 1'b1;
          if (track) begin
            exp_q.push_back(ref_res(a, b, rem));
            exp_tag_q.push_back(tag);
            exp_lat_q.push_back(is_special(a, b) ? 1 : LAT + 1);
            exp_en_q.push_back(is_special(a, b) ? 0 : LAT);
            acc_cyc_q.push_back(cyc);
          end
        end
      end
      if (!ok) chk(g, "req_ready_timeout", 32'd0, 32'd1);
      @(posedge clk); #1;
      req_valid = 1'b0;
    endtask

    task automatic wait_idle();
      bit ok = 1'b0;
      for (int i = 0; i < 500 && !ok; i++) begin
        @(negedge clk);
        ok = (exp_q.size() == 0) && !res_valid && !busy;
      end
      if (!ok) chk(g, "drain_timeout", 32'd0, 32'd1);
      @(posedge clk); #1;
    endtask

    task automatic check_cleared(input string where);
      @(negedge clk);
      chk(g, {where, "_oper_a"}, oper_a, '0);
      chk(g, {where, "_oper_b"}, oper_b, '0);
      chk(g, {where, "_operation"}, 32'(operation), 32'd0);
      chk(g, {where, "_enable_div"}, 32'(enable_div), 32'd0);
      chk(g, {where, "_res_valid"}, 32'(res_valid), 32'd0);
      chk(g, {where, "_res_data"}, res_data, '0);
      chk(g, {where, "_res_tag"}, 32'(res_tag), 32'd0);
      chk(g, {where, "_busy"}, 32'(busy), 32'd0);
      chk(g, {where, "_state"}, 32'(dbg_state), 32'd0);
    endtask

    initial begin
      logic [W-1:0] a, b;
      int           fdly;
      bit           ok;
      repeat (2) @(posedge clk);
      check_cleared("reset");
      @(posedge clk); #1;
      rst_n = 1'b1;

      // Directed: normal DIV/REM, divide by zero, signed overflow.
      issue(32'd100, 32'd7, 1'b0, 5'd3, 1'b1);
      issue(-32'sd100, 32'd7, 1'b1, 5'd4, 1'b1);
      issue(32'h1234, 32'd0, 1'b0, 5'd5, 1'b1);
      issue(32'h1234, 32'd0, 1'b1, 5'd6, 1'b1);
      issue(MIN_INT, 32'hFFFF_FFFF, 1'b0, 5'd7, 1'b1);
      issue(MIN_INT, 32'hFFFF_FFFF, 1'b1, 5'd8, 1'b1);
      wait_idle();

      // Backpressure: result held 10 cycles, a waiting request must not be taken.
      rdy_val = 1'b0;
      issue(32'd200, 32'd13, 1'b0, 5'd10, 1'b1);
      ok = 1'b0;
      for (int i = 0; i < 50 && !ok; i++) begin
        @(negedge clk);
        ok = res_valid;
      end
      if (!ok) chk(g, "res_valid_timeout", 32'd0, 32'd1);
      @(posedge clk); #1;
      req_a = 32'd300; req_b = -32'sd7; req_rem = 1'b1; req_tag = 5'd11; req_valid = 1'b1;
      repeat (10) begin
        @(negedge clk);
        chk(g, "req_ready_backpressure", 32'(req_ready), 32'd0);
      end
      @(posedge clk); #1;
      rdy_val = 1'b1;
      issue(32'd300, -32'sd7, 1'b1, 5'd11, 1'b1);
      wait_idle();

      // Flush mid-operation (2nd WAIT cycle when LAT=4, ISSUE cycle when LAT=1).
      fdly = (LAT > 2) ? 2 : 0;
      issue(32'd1000, 32'd9, 1'b0, 5'd12, 1'b0);
      repeat (fdly) @(posedge clk);
      #1;
      flush = 1'b1;
      req_a = 32'd5; req_b = 32'd1; req_valid = 1'b1;
      @(negedge clk);
      chk(g, "req_ready_during_flush", 32'(req_ready), 32'd0);
      @(posedge clk); #1;
      flush = 1'b0; req_valid = 1'b0;
      @(negedge clk);
      chk(g, "flush_busy", 32'(busy), 32'd0);
      chk(g, "flush_enable_div", 32'(enable_div), 32'd0);
      chk(g, "flush_res_valid", 32'(res_valid), 32'd0);
      repeat (6) @(posedge clk);
      #1;

      // Reset in the ISSUE cycle of a new operation, then a normal request.
      issue(32'd4242, 32'd17, 1'b1, 5'd13, 1'b0);
      rst_n = 1'b0;
      @(posedge clk);
      check_cleared("midop_reset");
      @(posedge clk); #1;
      rst_n = 1'b1;
      issue(32'd77, -32'sd5, 1'b0, 5'd14, 1'b1);
      wait_idle();

      // Random traffic with random writeback backpressure.
      bp_rand = 1'b1;
      for (int n = 0; n < 40; n++) begin
        int unsigned sel;
        sel = $urandom_range(0, 9);
        a = $urandom;
        b = $urandom;
        if (sel < 2) b = '0;
        else if (sel < 3) begin a = MIN_INT; b = '1; end
        else if (sel < 5) b = W'($urandom_range(1, 20));
        else if (sel < 6) b = -W'($urandom_range(1, 20));
        issue(a, b, 1'($urandom_range(0, 1)), TW'($urandom_range(0, 31)), 1'b1);
        repeat ($urandom_range(0, 2)) @(posedge clk);
        #1;
      end
      bp_rand = 1'b0;
      rdy_val = 1'b1;
      wait_idle();
      chk(g, "scoreboard_empty", 32'(exp_q.size()), 32'd0);
      done = 1'b1;
    end
  end

  initial begin
    bit fin = 1'b0;
    for (int i = 0; i < 50000 && !fin; i++) begin
      @(posedge clk);
      fin = g_inst[0].done && g_inst[1].done;
    end
    if (!fin) chk(0, "global_timeout", 32'd0, 32'd1);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/div_dispatch.md
Name: div_dispatch

Overview:
- Issue/retire controller placed directly upstream of the RV32IM divider; it drives the divider's operand/enable bus and captures its result.
- Accepts signed DIV/REM requests from decode over a valid/ready handshake and holds the operands stable for the divider's fixed latency.
- Returns the result to writeback over a valid/ready handshake.
- Resolves the RISC-V divide-by-zero and signed-overflow cases locally, without invoking the divider.

Parameters:
- length, 32, operand and result width in bits.
- DIV_LATENCY, 1, number of rising edges from the first cycle enable_div is high to the edge on which div_o is valid. Must be ≥1; 1 means a combinational divider.
- TAG_W, 5, width of the destination-register tag.

Ports:
- clk  input  1  clock; all logic on rising edge.
- rst_n  input  1  reset, synchronous, active-low.
- req_valid  input  1  decode presents a divide request.
- req_ready  output  1  dispatcher accepts the request this cycle.
- req_a  input  length  signed dividend.
- req_b  input  length  signed divisor.
- req_rem  input  1  0 = DIV (quotient), 1 = REM (remainder).
- req_tag  input  TAG_W  destination register tag.
- flush  input  1  kill any in-flight operation.
- oper_a  output  length  dividend to divider.
- oper_b  output  length  divisor to divider.
- operation  output  1  to divider: 0 = quotient, 1 = remainder.
- enable_div  output  1  divider enable.
- div_o  input  length  divider result.
- res_valid  output  1  result available.
- res_ready  input  1  writeback consumes the result.
- res_data  output  length  result value.
- res_tag  output  TAG_W  tag of the result.
- busy  output  1  high in any state other than IDLE.

Behaviour:
- Reset (rst_n = 0 at a rising edge):
  - State goes to IDLE.
  - oper_a, oper_b, operation, enable_div, res_valid, res_data, res_tag and the latency counter all clear to 0.
  - Reset applies mid-operation too; any in-flight result is discarded.
- States: IDLE, ISSUE, WAIT, DONE.
- req_ready = (state == IDLE) && !flush. A request is accepted when req_valid && req_ready at the edge.
- IDLE, on accept:
  - Latch req_a, req_b, req_rem and req_tag.
  - Special case, req_b == 0: res_data = DIV ? all-ones (−1) : req_a. Go to DONE.
  - Special case, req_a == 0x8000_0000 && req_b == −1: res_data = DIV ? 0x8000_0000 : 0. Go to DONE.
  - Otherwise, load oper_a/oper_b/operation and go to ISSUE.
- ISSUE / WAIT:
  - enable_div = 1.
  - oper_a, oper_b and operation are held constant throughout.
  - The counter starts at 1 on the first enable_div edge.
  - On the edge where counter == DIV_LATENCY, capture div_o into res_data, drop enable_div and go to DONE.
  - If DIV_LATENCY == 1, ISSUE goes straight to DONE. If DIV_LATENCY > 1, ISSUE goes to WAIT and the counter increments each edge.
- Special cases never assert enable_div.
- DONE:
  - res_valid = 1; res_data and res_tag are stable.
  - On res_ready, go to IDLE (res_valid falls the next cycle).
  - Under backpressure, hold indefinitely.
- Latency:
  - Normal path: accept edge to res_valid high = DIV_LATENCY + 1 edges.
  - Special path: 1 edge.
  - Throughput: 1 operation per DIV_LATENCY + 2 cycles with res_ready held high.
- Flush:
  - Highest priority after reset; acts in any state.
  - Next state is IDLE. enable_div, res_valid and the counter clear.
  - The dropped result is never presented.
  - A req_valid in the same cycle as flush is not accepted.
- Arithmetic: all operands are two's-complement, length bits. No sign manipulation beyond the special-case rules.
- busy = (state != IDLE).
- Outputs are registered except req_ready and busy, which decode state.

Test Plan:
- DIV_LATENCY = 1, req_a = 100, req_b = 7, req_rem = 0, tag = 3.
  - enable_div high for exactly 1 cycle with oper_a = 100, oper_b = 7.
  - res_valid 2 edges after accept, res_data = 14, res_tag = 3.
- DIV_LATENCY = 4, REM, a = −100, b = 7.
  - enable_div high 4 cycles, operands stable throughout.
  - res_data = −2 at accept + 5.
- Divide by zero, a = 0x1234, b = 0.
  - DIV gives 0xFFFF_FFFF; REM gives 0x1234.
  - res_valid 1 edge after accept; enable_div never high.
- Overflow, a = 0x8000_0000, b = −1.
  - DIV gives 0x8000_0000; REM gives 0.
  - 1-edge latency; divider untouched.
- Backpressure: res_ready held 0 for 10 cycles in DONE.
  - res_valid and res_data stable; req_ready = 0.
  - A new request is accepted only after the res_ready handshake.
- DIV_LATENCY = 4: flush in the 2nd WAIT cycle, then reset asserted mid-ISSUE on a new op.
  - Both cases reach IDLE next edge with enable_div = 0.
  - No res_valid pulse; all outputs 0 after reset.
  - A following request completes normally.
